// File: rtl/jam.sv
// -----------------------------------------------------------------------------
// jam -- Job Assignment Machine
//
// Finds the minimum total cost of a one-to-one assignment of 8 workers to
// 8 jobs. It reads the 8x8 table of 7-bit costs from an external ROM through
// the W/J address port and scores all 8! = 40320 permutations in
// lexicographic order. It reports the minimum total (MinCost) and how many
// permutations reach it (MatchCount, saturating at 15), then pulses Valid
// for one cycle. After that it idles until the next reset.
//
// Build option (define the macro to enable it):
//   JAM_CACHE_EN  The whole table is first copied into a 64x7 register file
//                 (LOAD, 65 cycles). EVAL then scores one permutation per
//                 cycle from that copy.
//                 Without the macro there is no copy. Each permutation
//                 streams its 8 costs straight from the ROM, taking
//                 9 cycles per permutation.
//
// Ports:
//   CLK         in   1   clock, all logic on the rising edge
//   RST         in   1   synchronous active-high reset; restarts the job
//   W           out  3   ROM address, worker index
//   J           out  3   ROM address, job index
//   Cost        in   7   ROM data cost[W][J], valid the cycle after W/J
//   MatchCount  out  4   number of optimal permutations (saturates at 15)
//   MinCost     out  10  minimum total cost
//   Valid       out  1   one-cycle strobe when MinCost/MatchCount update
// -----------------------------------------------------------------------------
module jam (
  input  logic       CLK,
  input  logic       RST,
  output logic [2:0] W,
  output logic [2:0] J,
  input  logic [6:0] Cost,
  output logic [3:0] MatchCount,
  output logic [9:0] MinCost,
  output logic       Valid
);

  typedef enum logic [1:0] {LOAD, EVAL, DONE, IDLE} state_t;

  state_t     state_q, state_d;

  // perm_q[w] = job currently assigned to worker w
  logic [2:0] perm_q    [8];
  logic [2:0] perm_d    [8];
  logic [2:0] perm_next [8];

  logic [2:0] w_q, w_d;
  logic [2:0] j_q, j_d;

  // running best total and how many permutations have hit it
  logic [9:0] min_q, min_d;
  logic [3:0] cnt_q, cnt_d;

  logic [9:0] min_cost_q, min_cost_d;
  logic [3:0] match_q, match_d;
  logic       valid_q, valid_d;

  // lexicographic successor helpers
  logic [2:0] piv;
  logic [2:0] swp;
  logic       has_piv;

  // score of the permutation being judged this cycle, and the best-tracking
  // state that would result from it
  logic [9:0] score;
  logic [9:0] min_upd;
  logic [3:0] cnt_upd;

  // ---------------------------------------------------------------------------
  // Next permutation.
  // The pivot is the largest i with p[i] < p[i+1].
  // The swap partner is the largest j > i with p[j] > p[i].
  // The successor swaps p[i] with p[j] and then reverses p[i+1..7].
  // ---------------------------------------------------------------------------
  always_comb begin
    piv     = '0;
    has_piv = 1'b0;
    swp     = '0;
    for (int k = 0; k < 7; k++) begin
      if (perm_q[k] < perm_q[k+1]) begin
        piv     = 3'(k);
        has_piv = 1'b1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      if ((3'(k) > piv) && (perm_q[k] > perm_q[piv])) begin
        swp = 3'(k);
      end
    end
  end

  // Positions above the pivot read the suffix backwards.
  // Slot k takes source index piv+8-k, which is piv-k modulo 8.
  // The swap is folded in: wherever the reversed source is the swap partner,
  // the old pivot value is substituted.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_next
      localparam logic [2:0] GI = 3'(gi);
      logic [2:0] src;
      assign src = piv - GI;
      assign perm_next[gi] = (GI < piv)  ? perm_q[gi]  :
                             (GI == piv) ? perm_q[swp] :
                             (src == swp) ? perm_q[piv] : perm_q[src];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Best tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    min_upd = min_q;
    cnt_upd = cnt_q;
    if (score < min_q) begin
      min_upd = score;
      cnt_upd = 4'd1;
    end else if ((score == min_q) && (cnt_q != 4'd15)) begin
      cnt_upd = cnt_q + 4'd1;
    end
  end

`ifdef JAM_CACHE_EN
  // ---------------------------------------------------------------------------
  // Cached build: copy the table, then score one permutation per cycle.
  // ---------------------------------------------------------------------------
  logic [6:0] cache_q [64];
  logic [6:0] cost_sel [8];
  logic [6:0] ld_q, ld_d;   // LOAD cycle index 0..64
  logic [6:0] ld_nxt;

  assign ld_nxt = ld_q + 7'd1;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
      assign cost_sel[gi] = cache_q[{3'(gi), perm_q[gi]}];
    end
  endgenerate

  always_comb begin
    score = '0;
    for (int k = 0; k < 8; k++) begin
      score = score + 10'(cost_sel[k]);
    end
  end

  // In LOAD cycle n the ROM returns the data for address n-1.
  always_ff @(posedge CLK) begin
    if (!RST && (state_q == LOAD) && (ld_q != 7'd0)) begin
      cache_q[6'(ld_q - 7'd1)] <= Cost;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Streaming build: 9 phases per permutation.
  // Phase k (0..7) presents worker k.
  // Phases 1..7 accumulate the cost for worker k-1.
  // Phase 8 adds the cost for worker 7, compares the total, and launches
  // address 0 of the next permutation.
  // ---------------------------------------------------------------------------
  logic [3:0] ph_q, ph_d;
  logic [9:0] acc_q, acc_d;

  assign score = acc_q + {3'b000, Cost};
`endif

  // ---------------------------------------------------------------------------
  // Control: next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    j_d        = j_q;
    min_d      = min_q;
    cnt_d      = cnt_q;
    min_cost_d = min_cost_q;
    match_d    = match_q;
    valid_d    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      perm_d[k] = perm_q[k];
    end
`ifdef JAM_CACHE_EN
    ld_d = ld_q;
`else
    ph_d  = ph_q;
    acc_d = acc_q;
`endif

    case (state_q)
      LOAD: begin
`ifdef JAM_CACHE_EN
        ld_d = ld_nxt;
        if (ld_q < 7'd63) begin
          w_d = ld_nxt[5:3];
          j_d = ld_nxt[2:0];
        end
        if (ld_q == 7'd64) begin
          state_d = EVAL;
          min_d   = 10'd1023;
          cnt_d   = 4'd0;
        end
`else
        state_d = EVAL;
        w_d     = 3'd0;
        j_d     = perm_q[0];
        ph_d    = 4'd0;
        min_d   = 10'd1023;
        cnt_d   = 4'd0;
`endif
      end

      EVAL: begin
`ifdef JAM_CACHE_EN
        min_d = min_upd;
        cnt_d = cnt_upd;
        if (has_piv) begin
          for (int k = 0; k < 8; k++) begin
            perm_d[k] = perm_next[k];
          end
        end else begin
          state_d = DONE;
        end
`else
        if (ph_q == 4'd8) begin
          min_d = min_upd;
          cnt_d = cnt_upd;
          if (has_piv) begin
            for (int k = 0; k < 8; k++) begin
              perm_d[k] = perm_next[k];
            end
            w_d  = 3'd0;
            j_d  = perm_next[0];
            ph_d = 4'd0;
          end else begin
            state_d = DONE;
          end
        end else begin
          ph_d = ph_q + 4'd1;
          if (ph_q == 4'd1) begin
            acc_d = {3'b000, Cost};
          end else if (ph_q != 4'd0) begin
            acc_d = acc_q + {3'b000, Cost};
          end
          if (ph_q < 4'd7) begin
            w_d = w_q + 3'd1;
            j_d = perm_q[w_q + 3'd1];
          end
        end
`endif
      end

      DONE: begin
        min_cost_d = min_q;
        match_d    = cnt_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end

      IDLE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= LOAD;
      w_q        <= 3'd0;
      j_q        <= 3'd0;
      min_q      <= 10'd1023;
      cnt_q      <= 4'd0;
      min_cost_q <= 10'd0;
      match_q    <= 4'd0;
      valid_q    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        perm_q[k] <= 3'(k);
      end
`ifdef JAM_CACHE_EN
      ld_q <= 7'd0;
`else
      ph_q  <= 4'd0;
      acc_q <= 10'd0;
`endif
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      j_q        <= j_d;
      min_q      <= min_d;
      cnt_q      <= cnt_d;
      min_cost_q <= min_cost_d;
      match_q    <= match_d;
      valid_q    <= valid_d;
      for (int k = 0; k < 8; k++) begin
        perm_q[k] <= perm_d[k];
      end
`ifdef JAM_CACHE_EN
      ld_q <= ld_d;
`else
      ph_q  <= ph_d;
      acc_q <= acc_d;
`endif
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign MinCost    = min_cost_q;
  assign MatchCount = match_q;
  assign Valid      = valid_q;

endmodule

// File: tb/tb_jam.sv
// -----------------------------------------------------------------------------
// tb_jam -- directed bench for jam.
// A registered ROM model returns cost[W][J] one cycle after the address.
// Each scenario task loads a table, runs the job, and checks the results.
// -----------------------------------------------------------------------------
module tb_jam;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost = 7'd0;
  logic [3:0] MatchCount;
  logic [9:0] MinCost;
  logic       Valid;

  logic [6:0] rom [64];

  int errors = 0;
  int checks = 0;

`ifdef JAM_CACHE_EN
  localparam int RUN_LIMIT = 40500;
`else
  localparam int RUN_LIMIT = 363000;
`endif

  always #5 CLK = ~CLK;

  // external ROM: one-cycle registered read
  always @(posedge CLK) Cost <= rom[{W, J}];

  jam dut (
    .CLK        (CLK),
    .RST        (RST),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .MatchCount (MatchCount),
    .MinCost    (MinCost),
    .Valid      (Valid)
  );

  // wait (bounded) for the Valid strobe, sampling on the falling edge
  task automatic wait_valid(output bit found, output int cyc);
    found = 1'b0;
    cyc   = 0;
    while (!found && cyc < RUN_LIMIT) begin
      @(negedge CLK);
      cyc++;
      if (Valid === 1'b1) found = 1'b1;
    end
  endtask

  // two-cycle reset pulse followed by a full run
  task automatic run_job(output bit found, output int cyc);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    wait_valid(found, cyc);
  endtask

  // brute-force reference: decode every index 0..40319 as a Lehmer code
  task automatic ref_eval(output int mn, output int cnt);
    int r, f, d, c, pick, s;
    bit [7:0] used;
    int fact [8];
    fact = '{1, 1, 2, 6, 24, 120, 720, 5040};
    mn  = 1023;
    cnt = 0;
    for (int idx = 0; idx < 40320; idx++) begin
      r    = idx;
      used = '0;
      s    = 0;
      for (int w = 0; w < 8; w++) begin
        f    = fact[7-w];
        d    = r / f;
        r    = r % f;
        c    = 0;
        pick = 0;
        for (int jj = 0; jj < 8; jj++) begin
          if (!used[jj]) begin
            if (c == d) pick = jj;
            c++;
          end
        end
        used[pick] = 1'b1;
        s += int'(rom[w*8 + pick]);
      end
      if (s < mn) begin
        mn  = s;
        cnt = 1;
      end else if (s == mn && cnt < 15) begin
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    $display("reset: W=%0d J=%0d Valid=%0b MinCost=%0d MatchCount=%0d", W, J, Valid, MinCost, MatchCount);
    checks++; if (W !== 3'd0) begin errors++; $display("FAIL reset_w: got %0d want 0", W); end
    checks++; if (J !== 3'd0) begin errors++; $display("FAIL reset_j: got %0d want 0", J); end
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", Valid); end
    checks++; if (MinCost !== 10'd0) begin errors++; $display("FAIL reset_mincost: got %0d want 0", MinCost); end
    checks++; if (MatchCount !== 4'd0) begin errors++; $display("FAIL reset_matchcount: got %0d want 0", MatchCount); end
  endtask

  // cost = |w-j|, aborted mid-EVAL by a 2-cycle reset and then rerun
  task automatic test_mid_reset();
    bit found;
    int cyc;
    for (int k = 0; k < 64; k++) rom[k] = 7'((k/8 > k%8) ? (k/8 - k%8) : (k%8 - k/8));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3000) @(negedge CLK);
    checks++; if (MinCost !== 10'd0) begin errors++; $display("FAIL midrst_early_mincost: got %0d want 0", MinCost); end
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL midrst_early_valid: got %0b want 0", Valid); end
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      $display("midrst: reset cycle %0d W=%0d J=%0d Valid=%0b", c, W, J, Valid);
      checks++; if (W !== 3'd0) begin errors++; $display("FAIL midrst_w: got %0d want 0", W); end
      checks++; if (J !== 3'd0) begin errors++; $display("FAIL midrst_j: got %0d want 0", J); end
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", Valid); end
    end
    RST = 1'b0;
    wait_valid(found, cyc);
    $display("absdiff rerun: MinCost=%0d MatchCount=%0d cycles=%0d", MinCost, MatchCount, cyc);
    checks++; if (!found) begin errors++; $display("FAIL absdiff_valid: no Valid within %0d cycles, want strobe", RUN_LIMIT); end
    checks++; if (MinCost !== 10'd0) begin errors++; $display("FAIL absdiff_mincost: got %0d want 0", MinCost); end
    checks++; if (MatchCount !== 4'd1) begin errors++; $display("FAIL absdiff_matchcount: got %0d want 1", MatchCount); end
    @(negedge CLK);
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL absdiff_strobe: Valid=%0b one cycle later, want 0", Valid); end
    checks++; if (MinCost !== 10'd0) begin errors++; $display("FAIL absdiff_hold: got %0d want 0", MinCost); end
  endtask

  // cost = 1 on the diagonal, 100 elsewhere
  task automatic test_diag();
    bit found;
    int cyc;
    for (int k = 0; k < 64; k++) rom[k] = (k/8 == k%8) ? 7'd1 : 7'd100;
    run_job(found, cyc);
    $display("diag: MinCost=%0d MatchCount=%0d cycles=%0d", MinCost, MatchCount, cyc);
    checks++; if (!found) begin errors++; $display("FAIL diag_valid: no Valid within %0d cycles, want strobe", RUN_LIMIT); end
    checks++; if (MinCost !== 10'd8) begin errors++; $display("FAIL diag_mincost: got %0d want 8", MinCost); end
    checks++; if (MatchCount !== 4'd1) begin errors++; $display("FAIL diag_matchcount: got %0d want 1", MatchCount); end
    @(negedge CLK);
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL diag_strobe: Valid=%0b one cycle later, want 0", Valid); end
  endtask

  // every cost at its maximum: largest total, saturated count
  task automatic test_all_max();
    bit found;
    int cyc;
    for (int k = 0; k < 64; k++) rom[k] = 7'd127;
    run_job(found, cyc);
    $display("allmax: MinCost=%0d MatchCount=%0d cycles=%0d", MinCost, MatchCount, cyc);
    checks++; if (!found) begin errors++; $display("FAIL allmax_valid: no Valid within %0d cycles, want strobe", RUN_LIMIT); end
    checks++; if (MinCost !== 10'd1016) begin errors++; $display("FAIL allmax_mincost: got %0d want 1016", MinCost); end
    checks++; if (MatchCount !== 4'd15) begin errors++; $display("FAIL allmax_matchcount: got %0d want 15", MatchCount); end
  endtask

  // cost = w+j: every permutation totals 56
  task automatic test_sum_const();
    bit found;
    int cyc;
    for (int k = 0; k < 64; k++) rom[k] = 7'(k/8 + k%8);
    run_job(found, cyc);
    $display("wplusj: MinCost=%0d MatchCount=%0d cycles=%0d", MinCost, MatchCount, cyc);
    checks++; if (!found) begin errors++; $display("FAIL wplusj_valid: no Valid within %0d cycles, want strobe", RUN_LIMIT); end
    checks++; if (MinCost !== 10'd56) begin errors++; $display("FAIL wplusj_mincost: got %0d want 56", MinCost); end
    checks++; if (MatchCount !== 4'd15) begin errors++; $display("FAIL wplusj_matchcount: got %0d want 15", MatchCount); end
  endtask

  // random table checked against the brute-force reference
  task automatic test_random();
    bit found;
    int cyc, exp_min, exp_cnt;
    for (int k = 0; k < 64; k++) rom[k] = 7'($urandom_range(127, 0));
    ref_eval(exp_min, exp_cnt);
    run_job(found, cyc);
    $display("random: MinCost=%0d MatchCount=%0d ref=%0d/%0d cycles=%0d", MinCost, MatchCount, exp_min, exp_cnt, cyc);
    checks++; if (!found) begin errors++; $display("FAIL random_valid: no Valid within %0d cycles, want strobe", RUN_LIMIT); end
    checks++; if (MinCost !== 10'(exp_min)) begin errors++; $display("FAIL random_mincost: got %0d want %0d", MinCost, exp_min); end
    checks++; if (MatchCount !== 4'(exp_cnt)) begin errors++; $display("FAIL random_matchcount: got %0d want %0d", MatchCount, exp_cnt); end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) rom[k] = 7'd0;
    test_reset();
    test_mid_reset();
    test_diag();
    test_all_max();
    test_sum_const();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
